// File: rtl/alu_mul_seq_pkg.sv
// Shared types and constants for the shift-add multiply sequencer and the shared ALU.
package alu_mul_seq_pkg;

   localparam int unsigned DATA_W   = 32;
   localparam int unsigned ALU_OP_W = 12;

   // Bit positions of the shared ALU one-hot operation vector.
   typedef enum int unsigned {
      ALU_BIT_ADD  = 0,
      ALU_BIT_SUB  = 1,
      ALU_BIT_SLT  = 2,
      ALU_BIT_SLTU = 3,
      ALU_BIT_AND  = 4,
      ALU_BIT_NOR  = 5,
      ALU_BIT_OR   = 6,
      ALU_BIT_XOR  = 7,
      ALU_BIT_SLL  = 8,
      ALU_BIT_SRL  = 9,
      ALU_BIT_SRA  = 10,
      ALU_BIT_LUI  = 11
   } alu_bit_e;

   // Sequencer state encoding.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ABS_A  = 3'd1,
      ST_ABS_B  = 3'd2,
      ST_STEP   = 3'd3,
      ST_NEG_LO = 3'd4,
      ST_NEG_HI = 3'd5,
      ST_DONE   = 3'd6
   } state_e;

   // One-hot ALU op vector with only the given bit set.
   function automatic logic [ALU_OP_W-1:0] alu_onehot(input alu_bit_e b);
      return ALU_OP_W'(1) << b;
   endfunction

endpackage

// File: rtl/alu_mul_seq_if.sv
// Request/response handshake plus shared-ALU drive/return signals of the multiply sequencer.
interface alu_mul_seq_if;
   import alu_mul_seq_pkg::*;

   logic                req_valid;
   logic                req_ready;
   logic                req_signed;
   logic [DATA_W-1:0]   req_a;
   logic [DATA_W-1:0]   req_b;
   logic                resp_valid;
   logic                resp_ready;
   logic [DATA_W-1:0]   resp_hi;
   logic [DATA_W-1:0]   resp_lo;
   logic                busy;
   logic [DATA_W-1:0]   alu_a;
   logic [DATA_W-1:0]   alu_b;
   logic [ALU_OP_W-1:0] alu_op;
   logic [DATA_W-1:0]   alu_result;
   logic                alu_carry;

   // Execute-stage side: issues requests, consumes products, hosts the ALU.
   modport master (
      output req_valid, req_signed, req_a, req_b, resp_ready, alu_result, alu_carry,
      input  req_ready, resp_valid, resp_hi, resp_lo, busy, alu_a, alu_b, alu_op
   );

   // Sequencer side.
   modport slave (
      input  req_valid, req_signed, req_a, req_b, resp_ready, alu_result, alu_carry,
      output req_ready, resp_valid, resp_hi, resp_lo, busy, alu_a, alu_b, alu_op
   );
endinterface

// File: rtl/alu_mul_seq.sv
// Multi-cycle 32x32->64 signed/unsigned multiplier that borrows the shared ALU for a shift-add loop.
module alu_mul_seq
   import alu_mul_seq_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned STEPS      = 32
) (
   input  logic         clk,
   input  logic         resetn,
   alu_mul_seq_if.slave bus
);

   localparam int unsigned CNT_W = $clog2(STEPS);
   localparam logic [ALU_OP_W-1:0] OP_ADD = alu_onehot(ALU_BIT_ADD);
   localparam logic [ALU_OP_W-1:0] OP_SUB = alu_onehot(ALU_BIT_SUB);
   localparam logic [ALU_OP_W-1:0] OP_NOR = alu_onehot(ALU_BIT_NOR);

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
   logic [DATA_WIDTH-1:0] hi_q, hi_d;
   logic [DATA_WIDTH-1:0] lo_q, lo_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  neg_q, neg_d;
   logic                  b_neg_q, b_neg_d;
   logic                  lo_zero_q, lo_zero_d;

   logic                  req_ready_q, req_ready_d;
   logic                  resp_valid_q, resp_valid_d;
   logic [DATA_WIDTH-1:0] resp_hi_q, resp_hi_d;
   logic [DATA_WIDTH-1:0] resp_lo_q, resp_lo_d;
   logic                  busy_q, busy_d;
   logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d;
   logic [DATA_WIDTH-1:0] alu_b_q, alu_b_d;
   logic [ALU_OP_W-1:0]   alu_op_q, alu_op_d;

   // Next state, datapath updates, and the registered outputs derived from the next state.
   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      cnt_d     = cnt_q;
      neg_d     = neg_q;
      b_neg_d   = b_neg_q;
      lo_zero_d = lo_zero_q;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.req_valid && req_ready_q) begin
               mcand_d = bus.req_a;
               lo_d    = bus.req_b;
               hi_d    = '0;
               cnt_d   = '0;
               neg_d   = bus.req_signed & (bus.req_a[DATA_WIDTH-1] ^ bus.req_b[DATA_WIDTH-1]);
               b_neg_d = bus.req_signed & bus.req_b[DATA_WIDTH-1];
               if (bus.req_signed && bus.req_a[DATA_WIDTH-1])      state_d = ST_ABS_A;
               else if (bus.req_signed && bus.req_b[DATA_WIDTH-1]) state_d = ST_ABS_B;
               else                                                state_d = ST_STEP;
            end
         end
         ST_ABS_A: begin
            mcand_d = bus.alu_result;
            state_d = b_neg_q ? ST_ABS_B : ST_STEP;
         end
         ST_ABS_B: begin
            lo_d    = bus.alu_result;
            state_d = ST_STEP;
         end
         ST_STEP: begin
            hi_d  = {bus.alu_carry, bus.alu_result[DATA_WIDTH-1:1]};
            lo_d  = {bus.alu_result[0], lo_q[DATA_WIDTH-1:1]};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(STEPS - 1)) state_d = neg_q ? ST_NEG_LO : ST_DONE;
         end
         ST_NEG_LO: begin
            lo_d      = bus.alu_result;
            lo_zero_d = (lo_q == '0);
            state_d   = ST_NEG_HI;
         end
         ST_NEG_HI: begin
            hi_d    = bus.alu_result;
            state_d = ST_DONE;
         end
         ST_DONE: begin
            if (bus.resp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // ALU drive for the cycle spent in the upcoming state.
      alu_a_d  = '0;
      alu_b_d  = '0;
      alu_op_d = '0;
      unique case (state_d)
         ST_ABS_A: begin
            alu_b_d  = mcand_d;
            alu_op_d = OP_SUB;
         end
         ST_ABS_B, ST_NEG_LO: begin
            alu_b_d  = lo_d;
            alu_op_d = OP_SUB;
         end
         ST_STEP: begin
            alu_a_d  = hi_d;
            alu_b_d  = lo_d[0] ? mcand_d : '0;
            alu_op_d = OP_ADD;
         end
         ST_NEG_HI: begin
            // A zero low word carries into the high word: full negate, else one's complement.
            if (lo_zero_d) begin
               alu_b_d  = hi_d;
               alu_op_d = OP_SUB;
            end else begin
               alu_a_d  = hi_d;
               alu_op_d = OP_NOR;
            end
         end
         default: ;
      endcase

      req_ready_d  = (state_d == ST_IDLE);
      resp_valid_d = (state_d == ST_DONE);
      busy_d       = (state_d != ST_IDLE) && (state_d != ST_DONE);
      resp_hi_d    = (state_d == ST_DONE) ? hi_d : resp_hi_q;
      resp_lo_d    = (state_d == ST_DONE) ? lo_d : resp_lo_q;
   end

   // State, datapath and output registers; reset aborts any op in flight.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= ST_IDLE;
         mcand_q      <= '0;
         hi_q         <= '0;
         lo_q         <= '0;
         cnt_q        <= '0;
         neg_q        <= 1'b0;
         b_neg_q      <= 1'b0;
         lo_zero_q    <= 1'b0;
         req_ready_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_hi_q    <= '0;
         resp_lo_q    <= '0;
         busy_q       <= 1'b0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_op_q     <= '0;
      end else begin
         state_q      <= state_d;
         mcand_q      <= mcand_d;
         hi_q         <= hi_d;
         lo_q         <= lo_d;
         cnt_q        <= cnt_d;
         neg_q        <= neg_d;
         b_neg_q      <= b_neg_d;
         lo_zero_q    <= lo_zero_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_hi_q    <= resp_hi_d;
         resp_lo_q    <= resp_lo_d;
         busy_q       <= busy_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_op_q     <= alu_op_d;
      end
   end

   assign bus.req_ready  = req_ready_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_hi    = resp_hi_q;
   assign bus.resp_lo    = resp_lo_q;
   assign bus.busy       = busy_q;
   assign bus.alu_a      = alu_a_q;
   assign bus.alu_b      = alu_b_q;
   assign bus.alu_op     = alu_op_q;

endmodule
